// File: rtl/spi_tx.sv
// SPI master transmit serializer: one word per valid/ready handshake, shifted out
// MSB-first on sdo with run-time CPOL/CPHA selection and a one-cycle end-of-transfer pulse.
module spi_tx #(
  parameter int          DLY          = 1,
  parameter int unsigned SPI_TX_WIDTH = 8,
  parameter int unsigned CLK_DIV      = 2,
  localparam int unsigned LW          = $clog2(SPI_TX_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cpol,
  input  logic                       cpoa,
  input  logic [LW-1:0]              length,
  input  logic [SPI_TX_WIDTH+LW-1:0] tx_data,
  input  logic                       tx_vld,
  output logic                       tx_rdy,
  output logic                       tx_eot,
  output logic                       sdo,
  output logic                       spi_bus_clk
);

  localparam int unsigned N  = SPI_TX_WIDTH;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // DLY only models a register update delay in simulation; it has no function here.
  if (CLK_DIV < 1 || DLY < 0) begin : g_param_check
    $error("spi_tx: CLK_DIV must be >= 1 and DLY must be >= 0");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  data, data_n;
  logic [LW-1:0] idx, idx_n;
  logic [DW-1:0] div, div_n;
  logic          half, half_n;
  logic          pol_q, pol_n;
  logic          pha_q, pha_n;
  logic          rdy_n, eot_n, sdo_n, sclk_n;

  logic [N-1:0]  payload;
  logic [LW-1:0] len_field;
  logic [LW-1:0] eff_len;

  // Effective frame length is the shorter of the per-word and the global limit.
  assign payload   = tx_data[N-1:0];
  assign len_field = tx_data[N +: LW];
  assign eff_len   = (len_field < length) ? len_field : length;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= IDLE;
      data        <= '0;
      idx         <= '0;
      div         <= '0;
      half        <= 1'b0;
      pol_q       <= 1'b0;
      pha_q       <= 1'b0;
      tx_rdy      <= 1'b0;
      tx_eot      <= 1'b0;
      sdo         <= 1'b0;
      spi_bus_clk <= 1'b0;
    end else begin
      state       <= state_n;
      data        <= data_n;
      idx         <= idx_n;
      div         <= div_n;
      half        <= half_n;
      pol_q       <= pol_n;
      pha_q       <= pha_n;
      tx_rdy      <= rdy_n;
      tx_eot      <= eot_n;
      sdo         <= sdo_n;
      spi_bus_clk <= sclk_n;
    end
  end

  // Next state and next registered outputs; output values describe the upcoming cycle.
  always_comb begin
    state_n = state;
    data_n  = data;
    idx_n   = idx;
    div_n   = div;
    half_n  = half;
    pol_n   = pol_q;
    pha_n   = pha_q;
    rdy_n   = 1'b0;
    eot_n   = 1'b0;
    sdo_n   = sdo;
    sclk_n  = spi_bus_clk;

    case (state)
      IDLE: begin
        rdy_n  = 1'b1;
        sclk_n = cpol;
        sdo_n  = 1'b0;
        if (tx_vld && tx_rdy) begin
          state_n = SHIFT;
          data_n  = payload;
          idx_n   = eff_len;
          div_n   = '0;
          half_n  = 1'b0;
          pol_n   = cpol;
          pha_n   = cpoa;
          rdy_n   = 1'b0;
          sdo_n   = payload[eff_len];
          sclk_n  = cpoa ? ~cpol : cpol;
        end
      end

      SHIFT: begin
        if (div == DW'(CLK_DIV - 1)) begin
          div_n = '0;
          if (!half) begin
            half_n = 1'b1;
            sclk_n = pha_q ? pol_q : ~pol_q;
          end else if (idx == '0) begin
            state_n = DONE;
            eot_n   = 1'b1;
            sdo_n   = 1'b0;
            sclk_n  = pol_q;
          end else begin
            half_n = 1'b0;
            idx_n  = idx - LW'(1);
            sdo_n  = data[idx - LW'(1)];
            sclk_n = pha_q ? ~pol_q : pol_q;
          end
        end else begin
          div_n = div + DW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
        sdo_n   = 1'b0;
        sclk_n  = cpol;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_tx.sv
// Directed bench for spi_tx (N=4, CLK_DIV=2): checks reset, all CPOL/CPHA modes,
// length clamping, back-to-back words with busy-time noise and mid-frame reset.
module tb_spi_tx;

  localparam int unsigned N  = 4;
  localparam int unsigned LW = 2;
  localparam int unsigned CD = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cpol = 1'b0;
  logic          cpoa = 1'b0;
  logic [LW-1:0] length = '0;
  logic [N+LW-1:0] tx_data = '0;
  logic          tx_vld = 1'b0;
  logic          tx_rdy;
  logic          tx_eot;
  logic          sdo;
  logic          spi_bus_clk;

  int errors = 0;
  int checks = 0;

  spi_tx #(
    .DLY(1),
    .SPI_TX_WIDTH(N),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cpol(cpol),
    .cpoa(cpoa),
    .length(length),
    .tx_data(tx_data),
    .tx_vld(tx_vld),
    .tx_rdy(tx_rdy),
    .tx_eot(tx_eot),
    .sdo(sdo),
    .spi_bus_clk(spi_bus_clk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (tx_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rdy_wait"}, 32'(tx_rdy), 32'(1));
  endtask

  // Sends one word and checks every cycle of the frame against the expected bit list
  // (exp[nbits-1] goes first). With noise set, tx_vld/cpol/cpoa toggle while busy.
  task automatic send(input logic [N+LW-1:0] word, input logic pol, input logic pha,
                      input logic [LW-1:0] len, input logic [3:0] exp, input int nbits,
                      input bit noise, input string tag);
    int   frame;
    logic h;
    logic exp_sclk;
    wait_rdy(tag);
    cpol    = pol;
    cpoa    = pha;
    length  = len;
    tx_data = word;
    tx_vld  = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    frame  = nbits * 2 * int'(CD);
    for (int k = 0; k < frame; k++) begin
      h        = ((k % 4) >= 2);
      exp_sclk = pha ? (h ? pol : ~pol) : (h ? ~pol : pol);
      chk($sformatf("%s sdo k%0d", tag, k), 32'(sdo), 32'(exp[nbits - 1 - k / 4]));
      chk($sformatf("%s sclk k%0d", tag, k), 32'(spi_bus_clk), 32'(exp_sclk));
      chk($sformatf("%s eot k%0d", tag, k), 32'(tx_eot), 32'(0));
      chk($sformatf("%s rdy k%0d", tag, k), 32'(tx_rdy), 32'(0));
      if (noise && k == 1) begin
        tx_vld  = 1'b1;
        tx_data = ~word;
        cpol    = ~pol;
        cpoa    = ~pha;
      end
      if (noise && k == frame - 2) begin
        tx_vld = 1'b0;
        cpol   = pol;
        cpoa   = pha;
      end
      @(negedge clk);
    end
    chk({tag, " done eot"}, 32'(tx_eot), 32'(1));
    chk({tag, " done rdy"}, 32'(tx_rdy), 32'(0));
    chk({tag, " done sclk"}, 32'(spi_bus_clk), 32'(pol));
    chk({tag, " done sdo"}, 32'(sdo), 32'(0));
    @(negedge clk);
    chk({tag, " idle eot"}, 32'(tx_eot), 32'(0));
    chk({tag, " idle rdy"}, 32'(tx_rdy), 32'(1));
  endtask

  initial begin
    logic [3:0] w;

    // Reset held for 10 cycles, then release with cpol=1.
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst rdy", 32'(tx_rdy), 32'(0));
    chk("rst sdo", 32'(sdo), 32'(0));
    chk("rst sclk", 32'(spi_bus_clk), 32'(0));
    chk("rst eot", 32'(tx_eot), 32'(0));
    cpol = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    chk("rel rdy", 32'(tx_rdy), 32'(1));
    chk("rel sclk", 32'(spi_bus_clk), 32'(1));
    chk("rel sdo", 32'(sdo), 32'(0));

    // Four CPOL/CPHA modes on the same word.
    send(6'b11_1010, 1'b1, 1'b1, 2'd3, 4'b1010, 4, 1'b0, "m11");
    send(6'b11_1010, 1'b0, 1'b0, 2'd3, 4'b1010, 4, 1'b0, "m00");
    send(6'b11_1010, 1'b1, 1'b0, 2'd3, 4'b1010, 4, 1'b0, "m10");
    send(6'b11_1010, 1'b0, 1'b1, 2'd3, 4'b1010, 4, 1'b0, "m01");

    // Clamp by global length, then by per-word length.
    send(6'b11_0110, 1'b0, 1'b0, 2'd1, 4'b0010, 2, 1'b0, "clamp_glb");
    send(6'b01_1001, 1'b1, 1'b0, 2'd3, 4'b0001, 2, 1'b0, "clamp_word");
    send(6'b00_1110, 1'b0, 1'b1, 2'd3, 4'b0000, 1, 1'b0, "one_bit");

    // Continuous source with random payloads and noise while busy.
    for (int i = 0; i < 4; i++) begin
      w = 4'($urandom_range(0, 15));
      send({2'b11, w}, 1'b0, 1'b1, 2'd3, w, 4, 1'b1, $sformatf("cont%0d", i));
    end

    // Reset in the middle of a frame.
    wait_rdy("midrst");
    cpol    = 1'b0;
    cpoa    = 1'b0;
    length  = 2'd3;
    tx_data = 6'b11_1111;
    tx_vld  = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst rdy", 32'(tx_rdy), 32'(0));
    chk("midrst sdo", 32'(sdo), 32'(0));
    chk("midrst sclk", 32'(spi_bus_clk), 32'(0));
    chk("midrst eot", 32'(tx_eot), 32'(0));
    @(negedge clk);
    chk("midrst eot2", 32'(tx_eot), 32'(0));
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst rel rdy", 32'(tx_rdy), 32'(1));
    chk("midrst rel eot", 32'(tx_eot), 32'(0));
    send(6'b11_0101, 1'b1, 1'b1, 2'd3, 4'b0101, 4, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
